// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - linear frequency-word sweep generator feeding the DDS accumulator
module dds_sweep_ctrl #(
    parameter int KW = 32,
    parameter int PW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [KW-1:0] f_start,
    input  logic [KW-1:0] f_stop,
    input  logic [KW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    input  logic [PW-1:0] p_off,
    input  logic [1:0]    mode,
    output logic [KW-1:0] K,
    output logic [PW-1:0] P,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_STEP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_REPEAT   = 2'b01;
    localparam logic [1:0] MODE_TRIANGLE = 2'b10;

    state_t        state_q;
    logic [KW-1:0] k_q;
    logic [PW-1:0] p_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] reload_q;
    logic [KW-1:0] lo_q;
    logic [KW-1:0] hi_q;
    logic [KW-1:0] fstart_q;
    logic [KW-1:0] step_q;
    logic [1:0]    mode_q;
    logic          dir_up_q;
    logic          base_up_q;

    logic [KW:0]   up_sum;
    logic [KW:0]   dn_diff;
    logic [KW-1:0] up_next_d;
    logic [KW-1:0] dn_next_d;
    logic          at_end;
    logic          cfg_bad;
    logic [DW-1:0] dwell_m1;

    // Candidate next words in both directions, one bit wider so carry/borrow
    // can be caught and clamped before it ever reaches the output.
    always_comb begin
        up_sum    = {1'b0, k_q} + {1'b0, step_q};
        dn_diff   = {1'b0, k_q} - {1'b0, step_q};
        up_next_d = (up_sum >= {1'b0, hi_q}) ? hi_q : up_sum[KW-1:0];
        dn_next_d = (dn_diff[KW] || (dn_diff[KW-1:0] <= lo_q)) ? lo_q : dn_diff[KW-1:0];
        at_end    = dir_up_q ? (k_q == hi_q) : (k_q == lo_q);
        cfg_bad   = (f_step == '0) || (f_start == f_stop);
        dwell_m1  = (dwell == '0) ? '0 : (dwell - DW'(1));
    end

    // Sweep FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            p_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            reload_q  <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            fstart_q  <= '0;
            step_q    <= '0;
            mode_q    <= 2'b00;
            dir_up_q  <= 1'b1;
            base_up_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            if (cfg_bad) begin
                                err_q <= 1'b1;
                            end else begin
                                state_q   <= S_DWELL;
                                k_q       <= f_start;
                                p_q       <= p_off;
                                busy_q    <= 1'b1;
                                cnt_q     <= dwell_m1;
                                reload_q  <= dwell_m1;
                                fstart_q  <= f_start;
                                step_q    <= f_step;
                                mode_q    <= mode;
                                lo_q      <= (f_start < f_stop) ? f_start : f_stop;
                                hi_q      <= (f_start < f_stop) ? f_stop : f_start;
                                dir_up_q  <= (f_start < f_stop);
                                base_up_q <= (f_start < f_stop);
                            end
                        end
                    end
                    S_DWELL: begin
                        if (cnt_q == '0) begin
                            state_q <= S_STEP;
                        end else begin
                            cnt_q <= cnt_q - DW'(1);
                        end
                    end
                    S_STEP: begin
                        state_q <= S_DWELL;
                        cnt_q   <= reload_q;
                        if (!at_end) begin
                            k_q <= dir_up_q ? up_next_d : dn_next_d;
                        end else begin
                            case (mode_q)
                                MODE_REPEAT: begin
                                    k_q      <= fstart_q;
                                    dir_up_q <= base_up_q;
                                end
                                MODE_TRIANGLE: begin
                                    // At an endpoint K equals that limit, so the
                                    // opposite-direction candidate is endpoint -/+ step.
                                    k_q      <= dir_up_q ? dn_next_d : up_next_d;
                                    dir_up_q <= ~dir_up_q;
                                end
                                default: begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                end
                            endcase
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign K    = k_q;
    assign P    = p_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - randomized self-checking bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;

    localparam int KW = 32;
    localparam int PW = 11;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [KW-1:0] f_start = '0;
    logic [KW-1:0] f_stop = '0;
    logic [KW-1:0] f_step = '0;
    logic [DW-1:0] dwell = '0;
    logic [PW-1:0] p_off = '0;
    logic [1:0]    mode = 2'b00;
    logic [KW-1:0] K;
    logic [PW-1:0] P;
    logic          busy;
    logic          done;
    logic          err;

    dds_sweep_ctrl #(.KW(KW), .PW(PW), .DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .f_start (f_start),
        .f_stop  (f_stop),
        .f_step  (f_step),
        .dwell   (dwell),
        .p_off   (p_off),
        .mode    (mode),
        .K       (K),
        .P       (P),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    longint        seq[$];
    logic [KW-1:0] mdl_k = '0;
    logic [PW-1:0] mdl_p = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_cfg();
        f_start = $urandom;
        f_stop  = $urandom;
        f_step  = $urandom;
        dwell   = DW'($urandom);
        p_off   = PW'($urandom);
        mode    = 2'($urandom);
    endtask

    // Append the clamped ramp a -> b to seq (optionally without its first value).
    function automatic void push_ramp(input longint a, input longint b, input longint s, input bit skip_first);
        longint v;
        bit first;
        v = a;
        first = 1'b1;
        while (1) begin
            if (!(skip_first && first)) seq.push_back(v);
            first = 1'b0;
            if (v == b || seq.size() >= 80) break;
            if (a < b) v = (v + s >= b) ? b : v + s;
            else       v = (v - s <= b) ? b : v - s;
        end
    endfunction

    task automatic run_sweep(input logic [KW-1:0] fs, input logic [KW-1:0] fe, input logic [KW-1:0] st,
                             input logic [DW-1:0] dw, input logic [PW-1:0] po, input logic [1:0] md,
                             input int ncyc);
        int     len;
        int     hold;
        int     idx;
        longint t;
        bit     single;
        logic [KW-1:0] expk;
        bit     expbusy;
        bit     expdone;

        seq.delete();
        single = (md == 2'b00) || (md == 2'b11);
        if (md == 2'b01) begin
            while (seq.size() < 64) push_ramp(fs, fe, st, 1'b0);
        end else if (md == 2'b10) begin
            push_ramp(fs, fe, st, 1'b0);
            while (seq.size() < 64) begin
                push_ramp(fe, fs, st, 1'b1);
                push_ramp(fs, fe, st, 1'b1);
            end
        end else begin
            push_ramp(fs, fe, st, 1'b0);
        end
        len  = seq.size();
        hold = ((dw == 0) ? 1 : int'(dw)) + 1;

        f_start = fs; f_stop = fe; f_step = st; dwell = dw; p_off = po; mode = md;
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble_cfg();
        expk = '0;
        expbusy = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            idx = n / hold;
            if (single && idx >= len) begin
                t = seq[len-1];
                expk = t[KW-1:0];
                expbusy = 1'b0;
                expdone = (n == len * hold);
            end else begin
                t = seq[idx];
                expk = t[KW-1:0];
                expbusy = 1'b1;
                expdone = 1'b0;
            end
            check_val("sweep_K", 64'(K), 64'(expk));
            check_val("sweep_P", 64'(P), 64'(po));
            check_val("sweep_busy", 64'(busy), 64'(expbusy));
            check_val("sweep_done", 64'(done), 64'(expdone));
            check_val("sweep_err", 64'(err), 64'(0));
            if (n < ncyc - 1) begin
                if (expbusy && $urandom_range(0, 7) == 0) begin
                    scramble_cfg();
                    start = 1'b1;
                end
                tick();
                start = 1'b0;
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_K", 64'(K), 64'(expk));
        check_val("abort_P", 64'(P), 64'(po));
        check_val("abort_busy", 64'(busy), 64'(0));
        check_val("abort_done", 64'(done), 64'(0));
        tick();
        check_val("idle_busy", 64'(busy), 64'(0));
        check_val("idle_K", 64'(K), 64'(expk));
        mdl_k = expk;
        mdl_p = po;
    endtask

    task automatic bad_start(input logic [KW-1:0] fs, input logic [KW-1:0] fe, input logic [KW-1:0] st);
        f_start = fs; f_stop = fe; f_step = st;
        dwell = DW'($urandom); p_off = PW'($urandom); mode = 2'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("err_pulse", 64'(err), 64'(1));
        check_val("err_busy", 64'(busy), 64'(0));
        check_val("err_K", 64'(K), 64'(mdl_k));
        check_val("err_P", 64'(P), 64'(mdl_p));
        tick();
        check_val("err_clear", 64'(err), 64'(0));
    endtask

    initial begin
        logic [KW-1:0] fs;
        logic [KW-1:0] fe;
        logic [KW-1:0] st;

        #12;
        check_val("rst_K", 64'(K), 64'(0));
        check_val("rst_P", 64'(P), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_done", 64'(done), 64'(0));
        check_val("rst_err", 64'(err), 64'(0));
        rst_n = 1'b1;
        tick();

        run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 11'd5, 2'b00, 15);
        run_sweep(32'd0, 32'd25, 32'd10, 16'd0, 11'd7, 2'b00, 11);
        run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 11'd3, 2'b00, 8);
        run_sweep(32'd50, 32'd80, 32'd15, 16'd1, 11'd9, 2'b10, 30);
        run_sweep(32'd40, 32'd10, 32'd15, 16'd1, 11'd1, 2'b01, 24);
        run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 11'd5, 2'b00, 4);
        bad_start(32'd100, 32'd130, 32'd0);
        bad_start(32'd77, 32'd77, 32'd5);

        // abort wins over a valid start in the same cycle
        f_start = 32'd10; f_stop = 32'd20; f_step = 32'd1; dwell = 16'd1; p_off = 11'd4; mode = 2'b00;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_val("abort_start_busy", 64'(busy), 64'(0));
        check_val("abort_start_err", 64'(err), 64'(0));
        check_val("abort_start_K", 64'(K), 64'(mdl_k));

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                fs = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
                fe = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            end else begin
                fs = 32'($urandom_range(0, 200));
                fe = 32'($urandom_range(0, 200));
            end
            st = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 60));
            if (st == 0 || fs == fe) bad_start(fs, fe, st);
            else run_sweep(fs, fe, st, DW'($urandom_range(0, 3)), PW'($urandom), 2'($urandom),
                           int'($urandom_range(4, 60)));
        end

        // asynchronous reset in the middle of a sweep
        f_start = 32'd100; f_stop = 32'd130; f_step = 32'd10; dwell = 16'd2; p_off = 11'd5; mode = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_K", 64'(K), 64'(0));
        check_val("arst_P", 64'(P), 64'(0));
        check_val("arst_busy", 64'(busy), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check_val("post_rst_busy", 64'(busy), 64'(0));
        check_val("post_rst_K", 64'(K), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
